// File: rtl/plot_pkg.sv
// Shared definitions for the VGA plot-port arbiter: FSM state encoding, default
// display geometry and the column one-hot helper.
package plot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_FINISH   = 3'd4
    } plot_state_e;

    localparam int N_COL_DEF   = 32'd64;
    localparam int ROW_W_DEF   = 32'd10;
    localparam int COLOR_W_DEF = 32'd8;

    // Widest column bus the helper can build; callers cast down to their own N_COL.
    localparam int COL_MAX_W   = 32'd12;
    localparam int N_COL_MAX   = 32'd4096;

    function automatic logic [N_COL_MAX-1:0] col_onehot(input logic [COL_MAX_W-1:0] col);
        logic [N_COL_MAX-1:0] v;
        v      = '0;
        v[col] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/plot_port_arbiter_rr.sv
// Combinational round-robin pick: lowest eligible requester index at or after ptr,
// where eligible means requesting and not masked.
module rr_arbiter
    import plot_pkg::*;
#(
    parameter int N_REQ = 32'd2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         mask,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    assign w_elig = req & ~mask;
    assign any    = |w_elig;

    // Cyclic scan starting at the pointer; the first eligible hit wins.
    always_comb begin
        w_found = 1'b0;
        w_pos   = '0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = IDX_W'((32'(ptr) + 32'(k)) % 32'(N_REQ));
            if (!w_found && w_elig[w_pos]) begin
                gnt_idx = w_pos;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/plot_port_arbiter.sv
// Serialises pixel writes from N_REQ plotters onto the one-hot VGA column port and
// runs the select / ack / release handshake, flagging columns that never answer.
module plot_port_arbiter
    import plot_pkg::*;
#(
    parameter int N_REQ   = 32'd2,
    parameter int N_COL   = N_COL_DEF,
    parameter int ROW_W   = ROW_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int TIMEOUT = 32'd1023
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*$clog2(N_COL)-1:0] col_in,
    input  logic [N_REQ*ROW_W-1:0]         row_in,
    input  logic [N_REQ*COLOR_W-1:0]       color_in,
    output logic [N_REQ-1:0]               done,
    output logic [$clog2(N_REQ)-1:0]       grant_id,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [N_COL-1:0]               col_select,
    output logic [ROW_W-1:0]               row_select,
    output logic [COLOR_W-1:0]             pixel_color,
    input  logic [N_COL-1:0]               return_sig
);

    localparam int COL_W = $clog2(N_COL);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'd1;
    // The wait expires on the TIMEOUT-th cycle spent in WAIT_ACK or RELEASE.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 32'sd0) ? CNT_W'(TIMEOUT - 32'sd1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    plot_state_e        r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [COLOR_W-1:0] r_color;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_COL-1:0]   r_col_select;
    logic [ROW_W-1:0]   r_row_select;
    logic [COLOR_W-1:0] r_pixel_color;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;
    logic               r_timeout_err;

    logic               w_any;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_ack;
    logic               w_expired;
    logic [CNT_W-1:0]   w_cnt_inc;

    // A requester is masked during the one cycle its done is high, so it cannot be
    // re-granted on the strength of a req it has not yet had a chance to drop.
    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req),
        .mask    (r_done),
        .ptr     (r_ptr),
        .any     (w_any),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ack     = return_sig[r_col];
    assign w_expired = (TIMEOUT > 32'sd0) && (r_cnt == CNT_LAST);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Handshake FSM together with request latches, wait counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_color       <= '0;
            r_cnt         <= '0;
            r_col_select  <= '0;
            r_row_select  <= '0;
            r_pixel_color <= '0;
            r_done        <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gnt_idx;
                        r_col   <= col_in[w_gnt_idx*COL_W +: COL_W];
                        r_row   <= row_in[w_gnt_idx*ROW_W +: ROW_W];
                        r_color <= color_in[w_gnt_idx*COLOR_W +: COLOR_W];
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_col_select  <= N_COL'(col_onehot(COL_MAX_W'(r_col)));
                    r_row_select  <= r_row;
                    r_pixel_color <= r_color;
                    r_cnt         <= '0;
                    r_state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (w_ack) begin
                        r_col_select <= '0;
                        r_cnt        <= '0;
                        r_state      <= ST_RELEASE;
                    end else if (w_expired) begin
                        r_col_select  <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_FINISH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    // Hold off until the ack drops so a later write to this column
                    // cannot be fooled by the ack that belongs to this one.
                    if (!w_ack) begin
                        r_state <= ST_FINISH;
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_FINISH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_FINISH: begin
                    r_done  <= {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
                    r_ptr   <= (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + {{(IDX_W-1){1'b0}}, 1'b1};
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_col_select <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign col_select  = r_col_select;
    assign row_select  = r_row_select;
    assign pixel_color = r_pixel_color;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Scoreboard bench for plot_port_arbiter: per-requester expectation queues, a column
// responder model and a transaction-level round-robin reference.
module tb_plot_port_arbiter;

    localparam int N_REQ   = 2;
    localparam int N_COL   = 64;
    localparam int COL_W   = 6;
    localparam int ROW_W   = 10;
    localparam int COLOR_W = 8;
    localparam int TIMEOUT = 16;
    localparam int NONE    = -1;   // column never acknowledges

    typedef struct { int col; int row; int color; int d; int h; } wr_t;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*COL_W-1:0]   col_in = '0;
    logic [N_REQ*ROW_W-1:0]   row_in = '0;
    logic [N_REQ*COLOR_W-1:0] color_in = '0;
    logic [N_REQ-1:0]         done;
    logic                     grant_id;
    logic                     busy;
    logic                     timeout_err;
    logic [N_COL-1:0]         col_select;
    logic [ROW_W-1:0]         row_select;
    logic [COLOR_W-1:0]       pixel_color;
    logic [N_COL-1:0]         return_sig;
    logic [N_COL-1:0]         resp_bits = '0;
    logic [N_COL-1:0]         noise_bits = '0;

    assign return_sig = resp_bits | noise_bits;

    plot_port_arbiter #(.N_REQ(N_REQ), .N_COL(N_COL), .ROW_W(ROW_W), .COLOR_W(COLOR_W),
                        .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .req(req), .col_in(col_in), .row_in(row_in),
        .color_in(color_in), .done(done), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .col_select(col_select), .row_select(row_select),
        .pixel_color(pixel_color), .return_sig(return_sig)
    );

    always #5 clock = ~clock;

    wr_t drv_q[N_REQ][$];
    wr_t exp_q[N_REQ][$];
    int  checks = 0;
    int  errors = 0;
    bit  churn_en = 0;
    bit  noise_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int col, input int row, input int color,
                        input int d, input int h);
        wr_t w;
        w.col = col; w.row = row; w.color = color; w.d = d; w.h = h;
        drv_q[i].push_back(w);
        exp_q[i].push_back(w);
    endtask

    // Requesters: hold req with the head write's data until its done pulse.
    always @(negedge clock) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (done[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            if (drv_q[i].size() > 0) begin
                req[i] = 1'b1;
                if (churn_en && busy && int'(grant_id) == i) begin
                    col_in[i*COL_W +: COL_W]       = COL_W'($urandom);
                    row_in[i*ROW_W +: ROW_W]       = ROW_W'($urandom);
                    color_in[i*COLOR_W +: COLOR_W] = COLOR_W'($urandom);
                end else begin
                    col_in[i*COL_W +: COL_W]       = COL_W'(drv_q[i][0].col);
                    row_in[i*ROW_W +: ROW_W]       = ROW_W'(drv_q[i][0].row);
                    color_in[i*COLOR_W +: COLOR_W] = COLOR_W'(drv_q[i][0].color);
                end
            end else begin
                req[i] = 1'b0;
                col_in[i*COL_W +: COL_W]       = COL_W'($urandom);
                row_in[i*ROW_W +: ROW_W]       = ROW_W'($urandom);
                color_in[i*COLOR_W +: COLOR_W] = COLOR_W'($urandom);
            end
        end
    end

    // Monitor + column responder + reference model.
    bit               active = 0, fell = 0, raised = 0, hold_ok = 0;
    int               dur, fcnt, rcnt, hcnt, cur_g, model_ptr = 0, g;
    bit               model_err = 0;
    wr_t              cur;
    logic [N_COL-1:0] cur_sel;

    always @(negedge clock) begin
        if (reset) begin
            active = 0; model_ptr = 0; model_err = 0; resp_bits = '0;
        end else begin
            if (!active && col_select != '0) begin
                g = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && req[(model_ptr + k) % N_REQ]) g = (model_ptr + k) % N_REQ;
                if (g < 0 || exp_q[g].size() == 0) begin
                    chk("write_expected", col_select, '0);
                end else begin
                    cur = exp_q[g][0]; cur_g = g; active = 1; fell = 0; raised = 0;
                    dur = 0; fcnt = 0; rcnt = 0; hcnt = 0; hold_ok = 1;
                    cur_sel = '0; cur_sel[cur.col] = 1'b1;
                    chk("grant_id", grant_id, g);
                    chk("col_select", col_select, cur_sel);
                    chk("row_select", row_select, cur.row);
                    chk("pixel_color", pixel_color, cur.color);
                    chk("stale_ack_low", return_sig[cur.col], 0);
                    chk("busy", busy, 1);
                end
            end
            if (active) begin
                if (!fell) begin
                    if (col_select != '0) begin
                        dur++;
                        if (col_select !== cur_sel || row_select != ROW_W'(cur.row) ||
                            pixel_color != COLOR_W'(cur.color) || done != '0) hold_ok = 0;
                        if (cur.d != NONE && !raised) begin
                            if (rcnt == cur.d) begin resp_bits[cur.col] = 1'b1; raised = 1; end
                            else rcnt++;
                        end
                        if (dur > 40) begin chk("select_bounded", dur, 40); active = 0; end
                    end else begin
                        fell = 1;
                        chk("select_cycles", dur, (cur.d == NONE) ? TIMEOUT : cur.d + 1);
                        chk("hold_values", hold_ok, 1);
                    end
                end
                if (active && fell) begin
                    if (raised && resp_bits[cur.col]) begin
                        if (hcnt == cur.h) resp_bits[cur.col] = 1'b0;
                        else hcnt++;
                    end
                    if (done != '0) begin
                        chk("done_vec", done, 1 << cur_g);
                        chk("done_delay", fcnt, raised ? cur.h + 2 : 1);
                        model_err = model_err | (cur.d == NONE);
                        chk("timeout_err", timeout_err, model_err);
                        void'(exp_q[cur_g].pop_front());
                        model_ptr = (cur_g + 1) % N_REQ;
                        active = 0;
                    end else if (fcnt > 40) begin
                        chk("done_bounded", fcnt, 40);
                        active = 0;
                    end
                    fcnt++;
                end
            end else if (done != '0) begin
                chk("spurious_done", done, 0);
            end
            noise_bits = noise_en ? {16'($urandom), 48'h0} : '0;
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() != 0 || active) && n < 3000) begin
            @(negedge clock); n++;
        end
        chk("drain_budget", n < 3000, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic sync();
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_col_select", col_select, 0);
        chk("rst_row_select", row_select, 0);
        chk("rst_pixel_color", pixel_color, 0);
        chk("rst_done", done, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        // Single write, ack after 3 cycles, release 1 cycle later.
        sync(); push(0, 5, 17, 8'hFF, 3, 1); drain();
        chk("t1_no_timeout", timeout_err, 0);

        // Contention: both held high, four writes each.
        sync();
        for (int k = 0; k < 4; k++) begin
            push(0, $urandom_range(0, 47), $urandom_range(0, 1023), $urandom_range(0, 255),
                 $urandom_range(0, 4), $urandom_range(0, 2));
            push(1, (k == 3) ? 63 : $urandom_range(0, 47), (k == 3) ? 63 : $urandom_range(0, 1023),
                 $urandom_range(0, 255), $urandom_range(0, 4), $urandom_range(0, 2));
        end
        drain();

        // Back-to-back writes to one column with a long-lived ack.
        sync(); push(0, 9, 1, 8'h33, 2, 6); push(0, 9, 2, 8'h44, 1, 1); drain();

        // Ack timeout, then a normal write; the error must stay sticky.
        sync(); push(1, 40, 5, 8'h06, NONE, 0); drain();
        sync(); push(0, 2, 7, 8'h08, 2, 1); drain();
        chk("t4_err_sticky", timeout_err, 1);

        // Input churn while granted.
        churn_en = 1;
        sync();
        for (int k = 0; k < 3; k++) begin
            push(0, $urandom_range(0, 47), $urandom_range(0, 1023), $urandom_range(0, 255), 2, 1);
            push(1, $urandom_range(0, 47), $urandom_range(0, 1023), $urandom_range(0, 255), 1, 0);
        end
        drain();
        churn_en = 0;

        // Reset while waiting for an ack on column 12.
        sync(); push(0, 12, 3, 8'h03, NONE, 0);
        n = 0;
        while (!col_select[12] && n < 50) begin @(negedge clock); n++; end
        chk("t5_select_seen", col_select[12], 1);
        repeat (3) @(negedge clock);
        sync();
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin drv_q[i].delete(); exp_q[i].delete(); end
        @(posedge clock); @(negedge clock);
        chk("t5_col_select", col_select, 0);
        chk("t5_row_select", row_select, 0);
        chk("t5_pixel_color", pixel_color, 0);
        chk("t5_done", done, 0);
        chk("t5_grant_id", grant_id, 0);
        chk("t5_busy", busy, 0);
        chk("t5_timeout_err", timeout_err, 0);
        reset = 1'b0;
        repeat (3) begin @(negedge clock); chk("t5_no_done", done, 0); end
        sync(); push(1, 30, 100, 8'h5A, 1, 0); drain();

        // Randomised batches with noise on columns that are never written.
        noise_en = 1;
        repeat (15) begin
            sync();
            for (int i = 0; i < N_REQ; i++) begin
                repeat ($urandom_range(0, 2))
                    push(i, $urandom_range(0, 47), $urandom_range(0, 1023), $urandom_range(0, 255),
                         ($urandom_range(0, 7) == 0) ? NONE : $urandom_range(0, 5),
                         $urandom_range(0, 3));
            end
            drain();
        end
        noise_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1);
    end

endmodule
